// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared inst-word layout, state encoding and widths for core_inst_seq
package core_pkg;

  localparam int ADDR_W = 4;
  localparam int CNT_W  = 5;
  localparam int INST_W = 17;

  localparam int OFIFO_RD  = 16;
  localparam int QKADD_MSB = 15;
  localparam int QKADD_LSB = 12;
  localparam int PADD_MSB  = 11;
  localparam int PADD_LSB  = 8;
  localparam int EXECUTE   = 7;
  localparam int LOAD      = 6;
  localparam int QMEM_RD   = 5;
  localparam int QMEM_WR   = 4;
  localparam int KMEM_RD   = 3;
  localparam int KMEM_WR   = 2;
  localparam int PMEM_RD   = 1;
  localparam int PMEM_WR   = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_QWR,
    S_QEND,
    S_KWR,
    S_KEND,
    S_KLD,
    S_KLDE,
    S_LDOFF,
    S_GAP1,
    S_EXE,
    S_EXEE,
    S_GAP2,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/core_inst_seq.sv
// rtl/core_inst_seq.sv - sequencer that streams Q/K into core and walks one attention-score pass
module core_inst_seq
  import core_pkg::*;
#(
  parameter int bw          = 8,
  parameter int pr          = 8,
  parameter int col         = 8,
  parameter int total_cycle = 8,
  parameter int gap_cycles  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [pr*bw-1:0]  in_data,
  input  logic              ofifo_valid,
  output logic [pr*bw-1:0]  mem_in,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
);

  if (col < 1 || col > 16 || total_cycle < 1 || total_cycle > 16 ||
      gap_cycles < 1 || gap_cycles > 32) begin : g_param_check
    $error("core_inst_seq: col/total_cycle must be 1..16 and gap_cycles 1..32");
  end

  localparam logic [CNT_W-1:0] Q_LAST    = CNT_W'(total_cycle - 1);
  localparam logic [CNT_W-1:0] K_LAST    = CNT_W'(col - 1);
  localparam logic [CNT_W-1:0] KLD_LAST  = CNT_W'(col);
  localparam logic [CNT_W-1:0] KEND_LAST = CNT_W'(2);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(gap_cycles - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [INST_W-1:0]  inst_d;
  logic               accept;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // cnt doubles as beat index, load-cycle index and gap timer depending on state
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: if (start) begin state_n = S_QWR; cnt_n = '0; end
      S_QWR: begin
        if (accept) begin
          if (cnt == Q_LAST) begin state_n = S_QEND; cnt_n = '0; end
          else cnt_n = cnt + 1'b1;
        end
      end
      S_QEND: begin state_n = S_KWR; cnt_n = '0; end
      S_KWR: begin
        if (accept) begin
          if (cnt == K_LAST) begin state_n = S_KEND; cnt_n = '0; end
          else cnt_n = cnt + 1'b1;
        end
      end
      S_KEND: begin
        if (cnt == KEND_LAST) begin state_n = S_KLD; cnt_n = '0; end
        else cnt_n = cnt + 1'b1;
      end
      S_KLD: begin
        if (cnt == KLD_LAST) begin state_n = S_KLDE; cnt_n = '0; end
        else cnt_n = cnt + 1'b1;
      end
      S_KLDE:  state_n = S_LDOFF;
      S_LDOFF: begin state_n = S_GAP1; cnt_n = '0; end
      S_GAP1: begin
        if (cnt == GAP_LAST) begin state_n = S_EXE; cnt_n = '0; end
        else cnt_n = cnt + 1'b1;
      end
      S_EXE: begin
        if (cnt == Q_LAST) begin state_n = S_EXEE; cnt_n = '0; end
        else cnt_n = cnt + 1'b1;
      end
      S_EXEE:  begin state_n = S_GAP2; cnt_n = '0; end
      S_GAP2: begin
        if (cnt == GAP_LAST) begin state_n = S_DRAIN; cnt_n = '0; end
        else cnt_n = cnt + 1'b1;
      end
      S_DRAIN: begin
        if (ofifo_valid) begin
          if (cnt == Q_LAST) begin state_n = S_DONE; cnt_n = '0; end
          else cnt_n = cnt + 1'b1;
        end
      end
      S_DONE:  begin state_n = S_IDLE; cnt_n = '0; end
      default: begin state_n = S_IDLE; cnt_n = '0; end
    endcase
  end

  always_comb begin
    inst_d = '0;
    case (state)
      S_QWR, S_KWR: begin
        // address stays put across stalled beats so core sees a stable word
        inst_d[QKADD_MSB:QKADD_LSB] = inst[QKADD_MSB:QKADD_LSB];
        if (accept) begin
          inst_d[QKADD_MSB:QKADD_LSB] = cnt[ADDR_W-1:0];
          inst_d[QMEM_WR] = (state == S_QWR);
          inst_d[KMEM_WR] = (state == S_KWR);
        end
      end
      S_KLD: begin
        inst_d[LOAD] = 1'b1;
        if (cnt != '0) begin
          inst_d[KMEM_RD] = 1'b1;
          inst_d[QKADD_MSB:QKADD_LSB] = ADDR_W'(cnt - CNT_W'(1));
        end
      end
      S_KLDE: inst_d[LOAD] = 1'b1;
      S_EXE: begin
        inst_d[EXECUTE] = 1'b1;
        inst_d[QMEM_RD] = 1'b1;
        inst_d[QKADD_MSB:QKADD_LSB] = cnt[ADDR_W-1:0];
      end
      S_DRAIN: begin
        inst_d[PADD_MSB:PADD_LSB] = inst[PADD_MSB:PADD_LSB];
        if (ofifo_valid) begin
          inst_d[OFIFO_RD] = 1'b1;
          inst_d[PMEM_WR]  = 1'b1;
          inst_d[PADD_MSB:PADD_LSB] = cnt[ADDR_W-1:0];
        end
      end
      default: inst_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst     <= '0;
      mem_in   <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      inst     <= inst_d;
      in_ready <= (state_n == S_QWR) || (state_n == S_KWR);
      busy     <= (state != S_IDLE) || (state_n != S_IDLE);
      done     <= (state == S_DONE);
      if (accept) mem_in <= in_data;
    end
  end

endmodule

// File: tb/tb_core_inst_seq.sv
// tb/tb_core_inst_seq.sv - randomized scoreboard bench for core_inst_seq
module tb_core_inst_seq;

  localparam int BW = 8, PR = 8, COL = 8, TC = 8, GAP = 10, DW = PR * BW;
  localparam int K_TO_DRAIN = 3 + (COL + 1) + 2 + GAP + TC + 1 + GAP;
  localparam int BASE_LAT   = 1 + TC + 1 + COL + K_TO_DRAIN + TC + 1;
  localparam logic [16:0] STRB  = 17'h100FF;
  localparam logic [16:0] M_QWR = 17'h00010, M_KWR = 17'h00004, M_LOAD = 17'h00040;
  localparam logic [16:0] M_KRD = 17'h00008, M_EXE = 17'h000A0, M_PW = 17'h10001;

  logic clk, reset, start, in_valid, in_ready, ofifo_valid, busy, done;
  logic [DW-1:0] in_data, mem_in;
  logic [16:0] inst;

  core_inst_seq #(.bw(BW), .pr(PR), .col(COL), .total_cycle(TC), .gap_cycles(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .ofifo_valid(ofifo_valid), .mem_in(mem_in), .inst(inst),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [16:0]   inst;
    logic          dn;
    logic [DW-1:0] data;
    bit            chk_data;
    bit            consec;
    int            exp_cyc;
  } ev_t;

  ev_t sb[$];
  ev_t cur;
  int n_tests = 0, n_fail = 0, cyc = 0, start_cyc = 0, last_ev = -100, kl = 0, pw_idx = 0;
  logic [DW-1:0] q_ref[TC], k_ref[COL], qm[16], km[16], ka[COL];
  logic [16:0] prev_inst;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [16:0] word(input logic [16:0] m, input int qa, input int pa);
    logic [16:0] v;
    v = m;
    v[15:12] = 4'(qa);
    v[11:8]  = 4'(pa);
    return v;
  endfunction

  function automatic int dot(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s = 0;
    for (int j = 0; j < PR; j++) s += int'(a[j*BW +: BW]) * int'(b[j*BW +: BW]);
    return s;
  endfunction

  task automatic push(input logic [16:0] i, input logic dn, input logic [DW-1:0] d,
                      input bit cd, input bit cs, input int ec);
    ev_t e;
    e.inst = i; e.dn = dn; e.data = d; e.chk_data = cd; e.consec = cs; e.exp_cyc = ec;
    sb.push_back(e);
  endtask

  // monitor: every strobe or done pulse must match the next expected event
  always @(negedge clk) begin
    if (!reset) prev_inst = '0;
    else begin
      if ((inst & STRB) != '0 || done) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_event: inst=%h done=%b with nothing expected (cycle %0d)", inst, done, cyc);
        end else begin
          cur = sb.pop_front();
          check("event_word", {done, inst}, {cur.dn, cur.inst});
          if (cur.chk_data) check("mem_in", mem_in, cur.data);
          if (cur.consec) check("event_spacing", cyc - last_ev, 1);
          if (cur.exp_cyc >= 0) begin
            check("done_cycle", cyc, cur.exp_cyc);
            check("busy_at_done", busy, 1);
          end
          if (inst[4]) qm[inst[15:12]] = mem_in;
          if (inst[2]) km[inst[15:12]] = mem_in;
          if (inst[3] && kl < COL) begin ka[kl] = km[inst[15:12]]; kl++; end
          if (inst[0] && pw_idx < TC) begin
            for (int c = 0; c < COL; c++)
              check("pmem_dot", dot(qm[inst[11:8]], ka[c]), dot(q_ref[pw_idx], k_ref[c]));
            pw_idx++;
          end
        end
        last_ev = cyc;
      end else if (inst != '0) check("addr_hold", inst[15:8], prev_inst[15:8]);
      prev_inst = inst;
    end
  end

  task automatic wait_ready();
    int g = 0;
    while (!in_ready && g < 100) begin @(posedge clk); #1; g++; end
    if (!in_ready) check("in_ready_timeout", 0, 1);
  endtask

  task automatic run_pass(input int qk_mode, input int dr_mode, input bit rst_mid, input bit spur);
    int stalls, k, g;
    stalls = 0; kl = 0; pw_idx = 0;
    for (int t = 0; t < TC; t++) q_ref[t] = {$urandom, $urandom};
    for (int c = 0; c < COL; c++) k_ref[c] = {$urandom, $urandom};
    @(posedge clk); #1; start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1; start = 1'b0;
    wait_ready();
    for (int t = 0; t < TC; t++) begin
      k = (qk_mode == 1) ? ((t > 0) ? 1 : 0) : (qk_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (k) begin in_valid = 1'b0; @(posedge clk); #1; end
      stalls += k;
      in_valid = 1'b1; in_data = q_ref[t];
      push(word(M_QWR, t, 0), 1'b0, q_ref[t], 1, 0, -1);
      @(posedge clk); #1;
    end
    if (qk_mode != 0) in_valid = 1'b0;
    wait_ready();
    for (int c = 0; c < COL; c++) begin
      k = (qk_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (k) begin in_valid = 1'b0; @(posedge clk); #1; end
      stalls += k;
      in_valid = 1'b1; in_data = k_ref[c]; start = spur && (c == 3);
      push(word(M_KWR, c, 0), 1'b0, k_ref[c], 1, 0, -1);
      @(posedge clk); #1; start = 1'b0;
    end
    in_valid = 1'b0;
    push(M_LOAD, 1'b0, '0, 0, 0, -1);
    for (int i = 1; i <= COL; i++) push(word(M_LOAD | M_KRD, i - 1, 0), 1'b0, '0, 0, 1, -1);
    push(M_LOAD, 1'b0, '0, 0, 1, -1);
    for (int t = 0; t < TC; t++) push(word(M_EXE, t, 0), 1'b0, '0, 0, t > 0, -1);
    if (rst_mid) begin
      repeat (3 + (COL + 1) + 2 + GAP + 4) @(posedge clk);
      #2;
      check("exe_before_reset", inst[7], 1);
      reset = 1'b0; #1;
      check("reset_mid_inst", inst, 0);
      check("reset_mid_busy", busy, 0);
      check("reset_mid_ready", in_ready, 0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1; reset = 1'b1;
      return;
    end
    for (int i = 0; i < K_TO_DRAIN; i++) begin
      start = spur && (i == K_TO_DRAIN - 5);
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int r = 0; r < TC; r++) begin
      k = (dr_mode == 1) ? ((r == 4) ? 3 : 0) : (dr_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (k) begin ofifo_valid = 1'b0; @(posedge clk); #1; end
      stalls += k;
      ofifo_valid = 1'b1;
      push(word(M_PW, 0, r), 1'b0, '0, 0, 0, -1);
      @(posedge clk); #1;
    end
    push('0, 1'b1, '0, 0, 1, start_cyc + BASE_LAT + stalls);
    g = 0;
    while (sb.size() != 0 && g < 200) begin @(posedge clk); #1; g++; end
    check("pass_drained", sb.size(), 0);
    sb.delete();
    @(posedge clk); #1;
    check("idle_busy", busy, 0);
    check("idle_ready", in_ready, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; ofifo_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_inst", inst, 0);
    check("rst_mem_in", mem_in, 0);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b1;
    in_valid = 1'b1; in_data = {$urandom, $urandom};
    repeat (3) begin @(posedge clk); #1; check("idle_no_ready", in_ready, 0); end
    in_valid = 1'b0;
    run_pass(0, 0, 0, 0);
    run_pass(1, 1, 0, 0);
    run_pass(0, 0, 1, 0);
    run_pass(0, 0, 0, 0);
    run_pass(0, 0, 0, 1);
    repeat (4) run_pass(2, 2, 0, 1'($urandom_range(0, 1)));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/core_inst_seq.md
Name: core_inst_seq

Overview:
- Hardware sequencer that replaces hand-driven stimulus in front of `core`.
- Accepts Q and K vectors over a valid/ready stream, drives `core.mem_in` and the 17-bit `core.inst` word, and runs one full attention-score pass:
  - Qmem write
  - Kmem write
  - K load into the array
  - execute
  - ofifo→pmem drain
- Sits directly upstream of `core`; all outputs are registered.

Parameters:
- bw, 8, Q/K element bit width
- pr, 8, elements per vector (mem_in lanes)
- col, 8, number of K vectors / dot-product columns; ≤16
- total_cycle, 8, number of Q vectors; ≤16
- gap_cycles, 10, idle cycles after load and after execute

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a pass; sampled only in IDLE
- in_valid  in  1  in_data beat valid
- in_ready  out  1  sequencer accepts a beat; 1 only in QWR/KWR
- in_data  in  pr*bw  vector, lane j = bits[(j+1)*bw-1:j*bw]
- ofifo_valid  in  1  core output FIFO has an entry
- mem_in  out  pr*bw  to core
- inst  out  17  to core: [16] ofifo_rd, [15:12] qkmem_add, [11:8] pmem_add, [7] execute, [6] load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a pass

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; counters=0; inst=0, mem_in=0, in_ready=0, busy=0, done=0.
- All outputs are registered. Fields not listed for a state are 0.
- One 5-bit counter `cnt`.
- States and per-cycle output:
  - IDLE: start=1 → QWR, cnt=0.
  - QWR: in_ready=1. On accepted beat (in_valid & in_ready): mem_in=in_data, qmem_wr=1, qkmem_add=cnt, cnt++. No beat → qmem_wr=0, address held. After total_cycle beats → QEND.
  - QEND: 1 cycle, all zero → KWR, cnt=0.
  - KWR: same as QWR with kmem_wr, col beats → KEND.
  - KEND: 1 cycle zero, then 2 further zero cycles → KLD, cnt=0.
  - KLD: col+1 cycles, load=1 throughout.
    - cycle 0: kmem_rd=0, add=0.
    - cycle i (1..col): kmem_rd=1, qkmem_add=i-1.
  - KLDE: 1 cycle, load=1, kmem_rd=0, add=0.
  - LDOFF: 1 cycle, all zero.
  - GAP1: gap_cycles zero cycles.
  - EXE: total_cycle cycles, execute=1, qmem_rd=1, qkmem_add=cnt.
  - EXEE: 1 cycle zero.
  - GAP2: gap_cycles zero cycles.
  - DRAIN:
    - When ofifo_valid=1: ofifo_rd=1, pmem_wr=1, pmem_add=cnt, cnt++.
    - When ofifo_valid=0: both low, pmem_add held.
    - After total_cycle reads → DONE.
  - DONE: 1 cycle, all zero, done=1 → IDLE.
- mem_in holds its last written value outside write beats.
- start while busy is ignored. start and in_valid in IDLE: the beat is not accepted (in_ready=0).
- Address wraps modulo 16. Parameter checks reject col or total_cycle >16 at elaboration.
- Reset mid-pass: immediate return to IDLE with all outputs zero. The core must be re-run from QWR; partial memory contents are not cleared.
- Stream stalls in QWR/KWR are unbounded; there is no timeout.
- Fixed latency with no stalls and defaults:
  - 8 cycles QWR, 1 QEND
  - 8 KWR, 3 KEND
  - 9 KLD, 1 KLDE, 1 LDOFF
  - 10 GAP1, 8 EXE, 1 EXEE, 10 GAP2
  - 8 DRAIN, 1 DONE
  - Total 70 cycles from start accept to done.

Decomposition:
- Shared package `core_pkg`:
  - inst bit-position localparams (OFIFO_RD=16, QKADD_MSB/LSB=15/12, PADD_MSB/LSB=11/8, EXECUTE=7 … PMEM_WR=0)
  - state enum/localparams
  - ADDR_W=4
- No sub-module: a single FSM plus counter. The bench binds core_inst_seq to `core` for integration.

Test Plan:
- Reset then start=1, in_valid held 1, ofifo_valid=1, Q/K from qdata.txt/kdata.txt:
  - done pulses exactly 70 cycles after start.
  - pmem contents equal Σ Q[t][k]·K[c][k] for all t, c.
- QWR with in_valid toggling 1,0,1,0: qmem_wr high only on accepted beats; qkmem_add sequence 0,·,1,·,2…; 8 writes total.
- KLD window: monitor sees load=1 for 10 consecutive cycles; kmem_rd=1 on cycles 2–9 with qkmem_add 0..7; load=0 on the 11th.
- DRAIN with ofifo_valid low 3 cycles midway: ofifo_rd/pmem_wr low during the gap; pmem_add continues without skipping (0..7); done is delayed by 3 cycles.
- Assert reset=0 during EXE (cycle 4): inst=0, busy=0 in the same cycle (asynchronous). After release, start is accepted and the full pass completes correctly.
- start pulsed during KWR and GAP2: no effect; cycle count unchanged at 70.
